// File: rtl/alu_seq_pkg.sv
// Shared types for the multi-nibble ALU sequencer:
// FSM states, nibble width and select codes.
package alu_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic s1;
    logic s0;
    logic m;
  } op_sel_t;

  // m=0 arithmetic (carry chained), m=1 bitwise logic (cin ignored)
  localparam op_sel_t OP_ADD = 3'b000;
  localparam op_sel_t OP_AND = 3'b001;
  localparam op_sel_t OP_SUB = 3'b010;
  localparam op_sel_t OP_OR  = 3'b011;
  localparam op_sel_t OP_INC = 3'b100;
  localparam op_sel_t OP_XOR = 3'b101;
  localparam op_sel_t OP_DEC = 3'b110;
  localparam op_sel_t OP_NOT = 3'b111;

endpackage

// File: rtl/alu_nibble_seq.sv
// Feeds a registered 4-bit ALU one nibble per cycle, LSB first.
// ALU_SEQ_ZERO_FLAG_EN adds a registered res_zero output.
module alu_nibble_seq
  import alu_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]  op_a,
  input  logic [NIBBLE_W*NIBBLES-1:0]  op_b,
  input  logic [2:0]                   op_sel,
  input  logic                         op_cin,
  output logic [NIBBLE_W-1:0]          alu_a,
  output logic [NIBBLE_W-1:0]          alu_b,
  output logic                         alu_cin,
  output logic                         alu_s1,
  output logic                         alu_s0,
  output logic                         alu_m,
  input  logic [NIBBLE_W-1:0]          alu_f,
  input  logic                         alu_cout,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0]  res,
  output logic                         res_cout
`ifdef ALU_SEQ_ZERO_FLAG_EN
  ,
  output logic                         res_zero
`endif
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  state_t        state;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  op_sel_t       sel_q;
  logic          cin_q;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_cin = 1'b0;
    alu_s1  = 1'b0;
    alu_s0  = 1'b0;
    alu_m   = 1'b0;
    if (state == RUN) begin
      for (int i = 0; i < NIBBLES; i++) begin
        if (int'(idx) == i) begin
          alu_a = a_q[i*NIBBLE_W +: NIBBLE_W];
          alu_b = b_q[i*NIBBLE_W +: NIBBLE_W];
        end
      end
      // alu_cout is the previous nibble's registered carry
      alu_cin = (idx == '0) ? cin_q : alu_cout;
      alu_s1  = sel_q.s1;
      alu_s0  = sel_q.s0;
      alu_m   = sel_q.m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= '0;
      cin_q    <= 1'b0;
      res      <= '0;
      res_cout <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
      res_zero <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= op_a;
            b_q      <= op_b;
            sel_q    <= op_sel_t'(op_sel);
            cin_q    <= op_cin;
            idx      <= '0;
            res      <= '0;
            res_cout <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            res_zero <= 1'b0;
`endif
            state    <= RUN;
          end
        end
        RUN: begin
          // alu_f now holds the result of nibble idx-1
          for (int i = 0; i < NIBBLES - 1; i++) begin
            if (int'(idx) == i + 1) begin
              res[i*NIBBLE_W +: NIBBLE_W] <= alu_f;
            end
          end
          if (idx == LAST) begin
            idx   <= '0;
            state <= DRAIN;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DRAIN: begin
          res[W-1 -: NIBBLE_W] <= alu_f;
          res_cout             <= alu_cout;
`ifdef ALU_SEQ_ZERO_FLAG_EN
          res_zero <= (res[W-NIBBLE_W-1:0] == '0)
                   && (alu_f == '0);
`endif
          state <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Randomized bench: sequencer plus a behavioural 4-bit ALU,
// checked against a wide-arithmetic reference model.
module tb_alu_nibble_seq;
  import alu_seq_pkg::*;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic [2:0]   op_sel = '0;
  logic         op_cin = 1'b0;
  logic [3:0]   alu_a;
  logic [3:0]   alu_b;
  logic         alu_cin;
  logic         alu_s1;
  logic         alu_s0;
  logic         alu_m;
  logic [3:0]   alu_f;
  logic         alu_cout;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] res;
  logic         res_cout;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic         res_zero;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_nibble_seq #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sel    (op_sel),
    .op_cin    (op_cin),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_cin   (alu_cin),
    .alu_s1    (alu_s1),
    .alu_s0    (alu_s0),
    .alu_m     (alu_m),
    .alu_f     (alu_f),
    .alu_cout  (alu_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .res_cout  (res_cout)
`ifdef ALU_SEQ_ZERO_FLAG_EN
    ,
    .res_zero  (res_zero)
`endif
  );

  function automatic logic [4:0] alu_nib(
    input logic [3:0] a, input logic [3:0] b,
    input logic c, input logic s1, input logic s0, input logic m);
    logic [3:0] nb;
    nb = ~b;
    if (m) begin
      case ({s1, s0})
        2'd0:    return {1'b0, a & b};
        2'd1:    return {1'b0, a | b};
        2'd2:    return {1'b0, a ^ b};
        default: return {1'b0, ~a};
      endcase
    end
    case ({s1, s0})
      2'd0:    return 5'(a) + 5'(b) + 5'(c);
      2'd1:    return 5'(a) + 5'(nb) + 5'(c);
      2'd2:    return 5'(a) + 5'(c);
      default: return 5'(a) + 5'd15 + 5'(c);
    endcase
  endfunction

  // registered ALU stage, reset by ~rst at the integrating level
  always_ff @(posedge clk) begin
    if (rst) {alu_cout, alu_f} <= '0;
    else {alu_cout, alu_f} <= alu_nib(alu_a, alu_b, alu_cin,
                                      alu_s1, alu_s0, alu_m);
  end

  function automatic logic [W:0] ref_op(
    input logic [W-1:0] a, input logic [W-1:0] b,
    input op_sel_t s, input logic c);
    logic [W:0] ea, eb, nb, ec, ones;
    ea   = {1'b0, a};
    eb   = {1'b0, b};
    nb   = {1'b0, ~b};
    ec   = {{W{1'b0}}, c};
    ones = {1'b0, {W{1'b1}}};
    case (s)
      OP_ADD:  return ea + eb + ec;
      OP_SUB:  return ea + nb + ec;
      OP_INC:  return ea + ec;
      OP_DEC:  return ea + ones + ec;
      OP_AND:  return {1'b0, a & b};
      OP_OR:   return {1'b0, a | b};
      OP_XOR:  return {1'b0, a ^ b};
      default: return {1'b0, ~a};
    endcase
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_res"}, 64'(res), 64'd0);
    chk({tag, "_res_cout"}, 64'(res_cout), 64'd0);
    chk({tag, "_alu"}, 64'({alu_a, alu_b, alu_cin,
                            alu_s1, alu_s0, alu_m}), 64'd0);
  endtask

  task automatic do_cmd(input logic [W-1:0] a, input logic [W-1:0] b,
                        input op_sel_t s, input logic c, input int bp);
    logic [W:0] exp;
    int n;
    exp = ref_op(a, b, s, c);
    @(negedge clk);
    chk("ready_idle", 64'(in_ready), 64'd1);
    op_a = a; op_b = b; op_sel = s; op_cin = c;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    op_a = W'($urandom); op_b = W'($urandom);
    op_sel = 3'($urandom); op_cin = 1'($urandom);
    n = 0;
    while (!out_valid && n < 4 * N + 10) begin
      chk("ready_busy", 64'(in_ready), 64'd0);
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(n), 64'(N + 1));
    chk("res", 64'(res), 64'(exp[W-1:0]));
    chk("res_cout", 64'(res_cout), 64'(exp[W]));
`ifdef ALU_SEQ_ZERO_FLAG_EN
    chk("res_zero", 64'(res_zero), 64'(exp[W-1:0] == '0));
`endif
    for (int i = 0; i < bp; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_res", 64'({res_cout, res}), 64'(exp));
      chk("hold_ready", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("back_idle", 64'(in_ready), 64'd1);
    chk("valid_drop", 64'(out_valid), 64'd0);
  endtask

  task automatic abort_at_idx2(input logic [W-1:0] a);
    @(negedge clk);
    op_a = a; op_b = '1; op_sel = OP_ADD; op_cin = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_alu_a", 64'(alu_a), 64'(a[11:8]));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle_zero("abort");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] ra, rb;
    repeat (3) @(negedge clk);
    chk_idle_zero("reset");
    rst = 1'b0;

    do_cmd(16'h00FF, 16'h0001, OP_ADD, 1'b0, 0);
    do_cmd(16'hFFFF, 16'h0001, OP_ADD, 1'b0, 0);
    do_cmd(16'hA5C3, 16'h0FF0, OP_AND, 1'b0, 3);
    do_cmd(16'h1234, 16'h1234, OP_SUB, 1'b1, 1);
    do_cmd(16'h0000, 16'h0000, OP_DEC, 1'b0, 0);

    abort_at_idx2(16'hBEEF);
    do_cmd(16'h7FFF, 16'h8001, OP_ADD, 1'b1, 2);

    for (int k = 0; k < 48; k++) begin
      ra = ($urandom_range(0, 5) == 0) ? '1 : W'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      do_cmd(ra, rb, op_sel_t'(3'($urandom)), 1'($urandom),
             $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_nibble_seq.md
# alu_nibble_seq

Multi-nibble operation sequencer feeding the registered 4-bit ALU stage (`ALU4bit`). It accepts a wide operand pair plus select code over a valid/ready handshake. It issues the operands to the ALU one nibble per cycle, least-significant first, chaining the ALU's registered carry-out into the next nibble's carry-in. It then reassembles the nibble results into a wide result with final carry, presented on an output valid/ready handshake.

## Interface
- `NIBBLES`, default 4: operand width in nibbles; data width is `W = 4*NIBBLES`; legal range 2..8.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  command valid.
- `in_ready`  out  1  sequencer can accept a command.
- `op_a`  in  W  operand A.
- `op_b`  in  W  operand B.
- `op_sel`  in  3  select code {s1,s0,m}.
- `op_cin`  in  1  carry into nibble 0.
- `alu_a`  out  4  nibble of A to ALU.
- `alu_b`  out  4  nibble of B to ALU.
- `alu_cin`  out  1  ALU carry-in.
- `alu_s1`, `alu_s0`, `alu_m`  out  1 each  ALU select.
- `alu_f`  in  4  ALU registered result.
- `alu_cout`  in  1  ALU registered carry-out.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `res`  out  W  assembled result.
- `res_cout`  out  1  carry-out of the most-significant nibble.

## Operation
- FSM states are `IDLE`, `RUN`, `DRAIN`, `DONE`. Nibble index `idx` is a counter of width clog2(NIBBLES).
- `IDLE`: `in_ready=1`.
  - On `in_valid`, latch `op_a`, `op_b`, `op_sel`, `op_cin`, set `idx=0`, clear `res`, and go to `RUN`.
- `RUN`: drive `alu_a/alu_b` with nibble `idx` of the latched operands and `alu_s1/s0/m` from the latched `op_sel`.
  - `alu_cin` is the latched `op_cin` when `idx==0`, otherwise `alu_cout`.
  - When `idx>=1`, capture `alu_f` into `res` nibble `idx-1`.
  - Increment `idx`. After `idx==NIBBLES-1`, go to `DRAIN`.
- `DRAIN`: capture `alu_f` into the top nibble and `alu_cout` into `res_cout`, then go to `DONE`.
- `DONE`: `out_valid=1`; `res` and `res_cout` are held stable. On `out_ready`, go to `IDLE`.
- Carry chaining is unconditional. In logic mode (m=1) the ALU ignores Cin; the sequencer does not special-case it.
- `in_valid` outside `IDLE` is ignored; the command is not consumed because `in_ready=0`.
- The ALU stage's active-low reset is driven by `~rst` at the integrating level.
- Reset values:
  - state `IDLE`, `idx=0`
  - `res=0`, `res_cout=0`, `out_valid=0`
  - `in_ready=1` (first cycle after reset)
  - all `alu_*` outputs 0 (driven 0 in `IDLE` and `DONE`)

## Timing
- Command accepted on edge E0 (`in_valid & in_ready`).
- `RUN` occupies the NIBBLES cycles after E0, one nibble issued per cycle.
- `DRAIN` is 1 cycle. `out_valid` rises after edge E(NIBBLES+1); for NIBBLES=4, that is 5 cycles after acceptance.
- Minimum command-to-command spacing is NIBBLES+3 cycles: `DONE` with `out_ready=1` goes to `IDLE`, and the next accept happens in `IDLE`.
- `alu_cin` is combinational from the ALU's `cout` register; there is no extra stage.
- `rst` asserted in any state:
  - at the next edge, return to `IDLE` with reset values;
  - the in-flight command is discarded;
  - no `out_valid` is produced for it.

## Configuration
- `ALU_SEQ_ZERO_FLAG_EN` defined: adds output `res_zero` (1 bit).
  - Registered in `DRAIN`: `res_zero=1` iff all W result bits, including the top nibble being captured, are 0; `res_cout` is excluded.
  - Valid with `out_valid`; reset value 0.
- Undefined: the port and its logic are absent.

## Structure
- Shared package `alu_seq_pkg` holds:
  - the FSM state enum;
  - `NIBBLE_W=4`;
  - the `op_sel` struct {s1,s0,m};
  - named select-code constants (`OP_ADD`, `OP_AND`, …) matching the ALU1bit function table.
- Single flat module; no natural sub-module. The ALU4bit is instantiated beside it at the integrating level, not inside it.

## Test plan
- NIBBLES=4, `OP_ADD`, `op_a=0x00FF`, `op_b=0x0001`, `op_cin=0` -> `res=0x0100`, `res_cout=0`; carry propagates across the nibble boundary.
- `OP_ADD`, `0xFFFF+0x0001`, cin=0 -> `res=0x0000`, `res_cout=1`, `res_zero=1` (macro on).
- Latency: accept at edge E0 -> `out_valid` first high after E5; `in_ready=0` from E0 until `IDLE` is re-entered.
- Backpressure: `out_ready=0` for 3 cycles in `DONE` -> `res` stable and `out_valid` held; `in_valid` pulses ignored; after the `out_ready` edge, `IDLE` and `in_ready=1`.
- `rst` asserted while `idx==2` -> next cycle: `IDLE`, `res=0`, `out_valid=0`, `alu_*=0`; a new command then completes correctly.
- `OP_AND` (m=1), `0xA5C3 & 0x0FF0` -> `res=0x05C0`.
